// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2-write/2-read register file with entry-0 hardwired zero and sequential runtime clear.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we0;
  logic              we1;

  // The cycle that accepts clear_req is already committed to the clear, so its writes are dropped.
  assign we0 = !rst && (state_q == S_IDLE) && !clear_req && wr_en0 && (wr_addr0 != '0);
  assign we1 = !rst && (state_q == S_IDLE) && !clear_req && wr_en1 && (wr_addr1 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (clear_req) begin
        state_q   <= S_CLEAR;
        clr_cnt_q <= '0;
        ready_q   <= 1'b0;
      end
    end else begin
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == '1) begin
        state_q <= S_IDLE;
        ready_q <= 1'b1;
      end
    end
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_CLEAR)) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  always_comb begin
    rd_data0 = '0;
    if (ready_q && (rd_addr0 != '0)) begin
      rd_data0 = mem_q[rd_addr0];
`ifdef REGFILE_BYPASS_EN
      if (wr_en0 && (wr_addr0 == rd_addr0)) rd_data0 = wr_data0;
      if (wr_en1 && (wr_addr1 == rd_addr0)) rd_data0 = wr_data1;
`endif
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (ready_q && (rd_addr1 != '0)) begin
      rd_data1 = mem_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
      if (wr_en1 && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
`endif
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - Directed plus randomized bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        ready;
  logic [4:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic        wr_en0, wr_en1;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;

  int          tests = 0;
  int          fails = 0;

  logic [31:0] ref_mem [32];
  int          busy = 0;   // clear cycles still to run; 0 means idle

  regfile_mp #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (busy != 0 || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en1 && wr_addr1 == a) return wr_data1;
    if (wr_en0 && wr_addr0 == a) return wr_data0;
`endif
    return ref_mem[a];
  endfunction

  task automatic sample();
    @(negedge clk);
    check("ready", {31'd0, ready}, {31'd0, busy == 0});
    check("rd_data0", rd_data0, exp_rd(rd_addr0));
    check("rd_data1", rd_data1, exp_rd(rd_addr1));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) busy = 32;
    else if (busy > 0) begin
      ref_mem[32 - busy] = 32'h0;
      busy--;
    end else if (clear_req) busy = 32;
    else begin
      if (wr_en0 && wr_addr0 != 0) ref_mem[wr_addr0] = wr_data0;
      if (wr_en1 && wr_addr1 != 0) ref_mem[wr_addr1] = wr_data1;
    end
    #1;
    rst = 1'b0; clear_req = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, n, 32);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    rst = 1'b1; clear_req = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
    rd_addr0 = 5'd5; rd_addr1 = 5'd0; wr_addr0 = 5'd0; wr_addr1 = 5'd0;
    wr_data0 = 32'h0; wr_data1 = 32'h0;

    // Power-up reset followed by the automatic clear
    rst = 1'b1;
    advance();
    count_busy("reset_clear_len");
    sample();
    check("rd_addr5_after_reset", rd_data0, 32'h0);
    advance();

    // Basic write and address-0 protection
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hDEADBEEF;
    step();
    rd_addr1 = 5'd3;
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'h12345678;
    sample();
    check("wr_addr3_read", rd_data1, 32'hDEADBEEF);
    advance();
    rd_addr0 = 5'd0;
    sample();
    check("addr0_zero", rd_data0, 32'h0);
    advance();

    // Write-port collision and dual commit
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11111111;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22222222;
    step();
    wr_en0 = 1'b1; wr_addr0 = 5'd8; wr_data0 = 32'h88888888;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h99999999;
    rd_addr0 = 5'd7;
    sample();
    check("collision_port1", rd_data0, 32'h22222222);
    advance();
    rd_addr0 = 5'd8; rd_addr1 = 5'd9;
    sample();
    check("dual_wr0", rd_data0, 32'h88888888);
    check("dual_wr1", rd_data1, 32'h99999999);
    advance();

    // Same-cycle read of the address being written
    wr_en0 = 1'b1; wr_addr0 = 5'd10; wr_data0 = 32'h0BADCAFE;
    step();
    rd_addr0 = 5'd10;
    wr_en0 = 1'b1; wr_addr0 = 5'd10; wr_data0 = 32'hCAFEF00D;
    sample();
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd_data0, 32'hCAFEF00D);
`else
    check("no_bypass_old_value", rd_data0, 32'h0BADCAFE);
`endif
    advance();
    sample();
    check("after_write_cycle", rd_data0, 32'hCAFEF00D);
    advance();

    // Fill, clear with a discarded write and writes attempted mid-clear
    for (int a = 1; a < 32; a++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(a); wr_data0 = 32'hA5A5A5A5;
      step();
    end
    clear_req = 1'b1;
    wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'h44444444;
    advance();
    begin
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
        wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h55555555;
        clear_req = 1'b1;
        step();
        n++;
      end
      check("runtime_clear_len", n, 32);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a); rd_addr1 = 5'(31 - a);
      sample();
      check("post_clear_rd0", rd_data0, 32'h0);
      check("post_clear_rd1", rd_data1, 32'h0);
    end
    advance();

    // Reset ten cycles into a clear restarts it
    clear_req = 1'b1;
    advance();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    advance();
    count_busy("reset_mid_clear_len");

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      wr_en0   = ($urandom_range(0, 3) != 0);
      wr_en1   = ($urandom_range(0, 2) == 0);
      wr_addr0 = 5'($urandom_range(0, 31));
      wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      wr_data0 = $urandom;
      wr_data1 = $urandom;
      rd_addr0 = ($urandom_range(0, 2) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 5'($urandom_range(0, 31));
      clear_req = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clear_req  input  1  one-cycle pulse requesting a runtime clear of all entries.
REQ-006 SHALL have port ready  output  1  high when the block is idle and accepting writes.
REQ-007 SHALL have ports rd_addr0, rd_addr1  input  ADDR_W  read port addresses.
REQ-008 SHALL have ports rd_data0, rd_data1  output  DATA_W  read port data.
REQ-009 SHALL have ports wr_en0, wr_en1  input  1  write enables for write ports 0 and 1.
REQ-010 SHALL have ports wr_addr0, wr_addr1  input  ADDR_W  write addresses.
REQ-011 SHALL have ports wr_data0, wr_data1  input  DATA_W  write data.

Function
REQ-012 SHALL implement two-state FSM: IDLE and CLEAR; ready = 1 only in IDLE.
REQ-013 SHALL make reads combinational (zero latency): rd_dataN reflects entry rd_addrN in the same cycle.
REQ-014 SHALL return 0 on any read of address 0; entry 0 is hardwired zero.
REQ-015 SHALL drive both rd_dataN to 0 whenever ready = 0.
REQ-016 SHALL in IDLE commit wr_dataN to entry wr_addrN at the rising edge when wr_enN = 1; new value visible to reads the next cycle.
REQ-017 SHALL ignore writes to address 0.
REQ-018 SHALL, when both write ports are enabled to the same address, store wr_data1 (port 1 wins); different addresses both commit.
REQ-019 SHALL ignore all writes while in CLEAR; no queuing.
REQ-020 SHALL in CLEAR write 0 to entry clr_cnt each cycle, clr_cnt counting 0 to DEPTH-1, then enter IDLE on the following edge; a clear occupies exactly DEPTH cycles.
REQ-021 SHALL on clear_req = 1 in IDLE enter CLEAR with clr_cnt = 0 at the next edge; writes presented in that same cycle are discarded.
REQ-022 SHALL ignore clear_req while already in CLEAR.
REQ-023 SHALL keep clr_cnt in ADDR_W bits; wrap from DEPTH-1 terminates the clear and does not restart it.

Reset
REQ-024 SHALL on rst = 1 at a rising edge set the FSM to CLEAR with clr_cnt = 0, irrespective of current state, including mid-clear (clear restarts from entry 0).
REQ-025 SHALL hold ready = 0 and rd_data0/1 = 0 from the first edge with rst = 1 until the clear completes; rst has priority over clear_req and writes.
REQ-026 SHALL leave all entries reading 0 after the post-reset clear; no initial-block contents are relied on.

Configuration
REQ-027 SHALL honour macro REGFILE_BYPASS_EN.
REQ-028 SHALL with REGFILE_BYPASS_EN defined forward same-cycle write data: if ready and wr_enN = 1 and wr_addrN = rd_addrM != 0, rd_dataM = wr_dataN, with port 1 taking priority over port 0.
REQ-029 SHALL without REGFILE_BYPASS_EN return the stored (pre-write) value in the write cycle; the new value appears the next cycle.

Verification
REQ-030 SHALL cover: rst high 1 cycle -> ready = 0 for 32 cycles (ADDR_W = 5), then ready = 1; reading addr 5 returns 0x00000000.
REQ-031 SHALL cover: write 0xDEADBEEF to addr 3 via port 0 -> next cycle rd_addr1 = 3 gives 0xDEADBEEF; write 0x12345678 to addr 0 -> rd_data0 at addr 0 stays 0.
REQ-032 SHALL cover: same cycle wr0 (addr 7, 0x11111111) and wr1 (addr 7, 0x22222222) -> addr 7 reads 0x22222222; wr0 addr 8 and wr1 addr 9 in one cycle -> both stored.
REQ-033 SHALL cover: rd_addr0 = 10 while writing 0xCAFEF00D to addr 10 -> rd_data0 = 0xCAFEF00D same cycle with REGFILE_BYPASS_EN, old value without it.
REQ-034 SHALL cover: fill addr 1..31 with 0xA5A5A5A5, pulse clear_req, write addr 4 during CLEAR -> ready low 32 cycles, afterwards all addresses read 0.
REQ-035 SHALL cover: rst asserted 10 cycles into a clear -> clear restarts, ready returns high exactly 32 cycles after the rst edge.
